// File: rtl/rename_register_file_if.sv
// Operand-lookup, dispatch-allocation and ROB-retire bundle between the
// instruction buffer / ROB (master) and the rename register file (slave).
interface rename_register_file_if #(
    parameter int WIDTH  = 4,
    parameter int NREGS  = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    localparam int IDX_W = $clog2(NREGS);

    logic [WIDTH*IDX_W-1:0]  ra_idx;
    logic [WIDTH*IDX_W-1:0]  rb_idx;
    logic [WIDTH*DATA_W-1:0] ra_value;
    logic [WIDTH-1:0]        ra_busy;
    logic [WIDTH*TAG_W-1:0]  ra_owner;
    logic [WIDTH*DATA_W-1:0] rb_value;
    logic [WIDTH-1:0]        rb_busy;
    logic [WIDTH*TAG_W-1:0]  rb_owner;

    logic [WIDTH-1:0]        alloc_valid;
    logic [WIDTH*IDX_W-1:0]  alloc_rt;
    logic [WIDTH*TAG_W-1:0]  alloc_tag;

    logic [WIDTH-1:0]        wr_en;
    logic [WIDTH*IDX_W-1:0]  wr_target;
    logic [WIDTH*DATA_W-1:0] wr_data;
    logic [WIDTH*TAG_W-1:0]  wr_writer;

    modport master (
        output ra_idx, rb_idx,
        input  ra_value, ra_busy, ra_owner, rb_value, rb_busy, rb_owner,
        output alloc_valid, alloc_rt, alloc_tag,
        output wr_en, wr_target, wr_data, wr_writer
    );

    modport slave (
        input  ra_idx, rb_idx,
        output ra_value, ra_busy, ra_owner, rb_value, rb_busy, rb_owner,
        input  alloc_valid, alloc_rt, alloc_tag,
        input  wr_en, wr_target, wr_data, wr_writer
    );
endinterface

// File: rtl/rename_register_file.sv
// Architectural register file with per-register busy/owner rename state.
// Dispatch claims ownership; in-order retire writes value and releases ownership.
module rename_register_file #(
    parameter int WIDTH  = 4,
    parameter int NREGS  = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rename_register_file_if.slave  rf
);
    localparam int IDX_W = $clog2(NREGS);

    logic [DATA_W-1:0] value_q [NREGS];
    logic [DATA_W-1:0] value_d [NREGS];
    logic [TAG_W-1:0]  owner_q [NREGS];
    logic [TAG_W-1:0]  owner_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;

    // Next-state: per register, the youngest retire port and youngest alloc slot win.
    always_comb begin : next_state
        logic              ret_hit;
        logic [DATA_W-1:0] ret_data;
        logic [TAG_W-1:0]  ret_writer;
        logic              al_hit;
        logic [TAG_W-1:0]  al_tag;

        value_d    = value_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        ret_hit    = 1'b0;
        ret_data   = '0;
        ret_writer = '0;
        al_hit     = 1'b0;
        al_tag     = '0;

        for (int r = 1; r < NREGS; r++) begin
            ret_hit    = 1'b0;
            ret_data   = '0;
            ret_writer = '0;
            al_hit     = 1'b0;
            al_tag     = '0;

            for (int i = 0; i < WIDTH; i++) begin
                if (rf.wr_en[i] && (rf.wr_target[i*IDX_W +: IDX_W] == IDX_W'(r))) begin
                    ret_hit    = 1'b1;
                    ret_data   = rf.wr_data[i*DATA_W +: DATA_W];
                    ret_writer = rf.wr_writer[i*TAG_W +: TAG_W];
                end
                if (rf.alloc_valid[i] && (rf.alloc_rt[i*IDX_W +: IDX_W] == IDX_W'(r))) begin
                    al_hit = 1'b1;
                    al_tag = rf.alloc_tag[i*TAG_W +: TAG_W];
                end
            end

            if (ret_hit) begin
                value_d[r] = ret_data;
                // Only the current owner may release; a newer producer keeps the register busy.
                if ((owner_q[r] == ret_writer) && !al_hit) begin
                    busy_d[r] = 1'b0;
                end
            end

            if (al_hit) begin
                busy_d[r]  = 1'b1;
                owner_d[r] = al_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int r = 0; r < NREGS; r++) begin
                value_q[r] <= '0;
                owner_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREGS; r++) begin
                value_q[r] <= value_d[r];
                owner_q[r] <= owner_d[r];
            end
        end
    end

    // Combinational lookups from current state; r0 is forced to zero.
    always_comb begin : read_ports
        logic [IDX_W-1:0] ia;
        logic [IDX_W-1:0] ib;

        rf.ra_value = '0;
        rf.ra_busy  = '0;
        rf.ra_owner = '0;
        rf.rb_value = '0;
        rf.rb_busy  = '0;
        rf.rb_owner = '0;
        ia          = '0;
        ib          = '0;

        for (int s = 0; s < WIDTH; s++) begin
            ia = rf.ra_idx[s*IDX_W +: IDX_W];
            ib = rf.rb_idx[s*IDX_W +: IDX_W];
            if (ia != '0) begin
                rf.ra_value[s*DATA_W +: DATA_W] = value_q[ia];
                rf.ra_busy[s]                   = busy_q[ia];
                rf.ra_owner[s*TAG_W +: TAG_W]   = owner_q[ia];
            end
            if (ib != '0) begin
                rf.rb_value[s*DATA_W +: DATA_W] = value_q[ib];
                rf.rb_busy[s]                   = busy_q[ib];
                rf.rb_owner[s*TAG_W +: TAG_W]   = owner_q[ib];
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Scoreboard bench for rename_register_file: directed scenarios plus random
// dispatch/retire traffic against an array-based reference model.
module tb_rename_register_file;
    localparam int WIDTH  = 4;
    localparam int NREGS  = 16;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int IDX_W  = 4;

    typedef struct {
        logic [WIDTH*DATA_W-1:0] av;
        logic [WIDTH-1:0]        ab;
        logic [WIDTH*TAG_W-1:0]  ao;
        logic [WIDTH*DATA_W-1:0] bv;
        logic [WIDTH-1:0]        bb;
        logic [WIDTH*TAG_W-1:0]  bo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rename_register_file_if #(.WIDTH(WIDTH), .NREGS(NREGS), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    rename_register_file #(.WIDTH(WIDTH), .NREGS(NREGS), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] m_val  [NREGS];
    logic              m_busy [NREGS];
    logic [TAG_W-1:0]  m_own  [NREGS];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_val[r]  = '0;
            m_busy[r] = 1'b0;
            m_own[r]  = '0;
        end
    endfunction

    // Architectural rules applied to the inputs present at a clock edge.
    function automatic void model_edge();
        for (int r = 1; r < NREGS; r++) begin
            int rp = -1;
            int ap = -1;
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.wr_en[i] && int'(bus.wr_target[i*IDX_W +: IDX_W]) == r) rp = i;
                if (bus.alloc_valid[i] && int'(bus.alloc_rt[i*IDX_W +: IDX_W]) == r) ap = i;
            end
            if (rp >= 0) begin
                m_val[r] = bus.wr_data[rp*DATA_W +: DATA_W];
                if (m_own[r] == bus.wr_writer[rp*TAG_W +: TAG_W] && ap < 0) m_busy[r] = 1'b0;
            end
            if (ap >= 0) begin
                m_busy[r] = 1'b1;
                m_own[r]  = bus.alloc_tag[ap*TAG_W +: TAG_W];
            end
        end
    endfunction

    task automatic push_expect();
        exp_t e;
        for (int s = 0; s < WIDTH; s++) begin
            int ia = int'(bus.ra_idx[s*IDX_W +: IDX_W]);
            int ib = int'(bus.rb_idx[s*IDX_W +: IDX_W]);
            e.av[s*DATA_W +: DATA_W] = (ia == 0) ? '0   : m_val[ia];
            e.ab[s]                  = (ia == 0) ? 1'b0 : m_busy[ia];
            e.ao[s*TAG_W +: TAG_W]   = (ia == 0) ? '0   : m_own[ia];
            e.bv[s*DATA_W +: DATA_W] = (ib == 0) ? '0   : m_val[ib];
            e.bb[s]                  = (ib == 0) ? 1'b0 : m_busy[ib];
            e.bo[s*TAG_W +: TAG_W]   = (ib == 0) ? '0   : m_own[ib];
        end
        exp_q.push_back(e);
    endtask

    task automatic clr();
        bus.alloc_valid = '0;
        bus.alloc_rt    = '0;
        bus.alloc_tag   = '0;
        bus.wr_en       = '0;
        bus.wr_target   = '0;
        bus.wr_data     = '0;
        bus.wr_writer   = '0;
        bus.ra_idx      = 16'($urandom);
        bus.rb_idx      = 16'($urandom);
    endtask

    task automatic set_alloc(input int s, input int rt, input int tag);
        bus.alloc_valid[s]                = 1'b1;
        bus.alloc_rt[s*IDX_W +: IDX_W]    = IDX_W'(rt);
        bus.alloc_tag[s*TAG_W +: TAG_W]   = TAG_W'(tag);
    endtask

    task automatic set_wr(input int p, input int tgt, input int data, input int writer);
        bus.wr_en[p]                      = 1'b1;
        bus.wr_target[p*IDX_W +: IDX_W]   = IDX_W'(tgt);
        bus.wr_data[p*DATA_W +: DATA_W]   = DATA_W'(data);
        bus.wr_writer[p*TAG_W +: TAG_W]   = TAG_W'(writer);
    endtask

    task automatic set_rd(input int s, input int ra, input int rb);
        bus.ra_idx[s*IDX_W +: IDX_W] = IDX_W'(ra);
        bus.rb_idx[s*IDX_W +: IDX_W] = IDX_W'(rb);
    endtask

    // Called one time unit after a rising edge; inputs already driven.
    task automatic step();
        push_expect();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        clr();
        push_expect();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic random_bundle();
        clr();
        for (int s = 0; s < WIDTH; s++) begin
            if ($urandom_range(1, 0) == 1)
                set_alloc(s, $urandom_range(NREGS-1, 0), $urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1) begin
                int tgt = $urandom_range(NREGS-1, 0);
                int wtr = ($urandom_range(1, 0) == 1) ? int'(m_own[tgt]) : $urandom_range(15, 0);
                set_wr(s, tgt, $urandom_range(16'hFFFF, 0), wtr);
            end
        end
    endtask

    // Monitor: read outputs are always presented; compare one bundle per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int s = 0; s < WIDTH; s++) begin
                n_checks++;
                if (bus.ra_value[s*DATA_W +: DATA_W] === e.av[s*DATA_W +: DATA_W] &&
                    bus.ra_busy[s] === e.ab[s] &&
                    bus.ra_owner[s*TAG_W +: TAG_W] === e.ao[s*TAG_W +: TAG_W])
                    n_pass++;
                else
                    $display("FAIL rd_a slot%0d idx%0d t=%0t: got %h/%b/%h expected %h/%b/%h", s,
                             bus.ra_idx[s*IDX_W +: IDX_W], $time,
                             bus.ra_value[s*DATA_W +: DATA_W], bus.ra_busy[s], bus.ra_owner[s*TAG_W +: TAG_W],
                             e.av[s*DATA_W +: DATA_W], e.ab[s], e.ao[s*TAG_W +: TAG_W]);
                n_checks++;
                if (bus.rb_value[s*DATA_W +: DATA_W] === e.bv[s*DATA_W +: DATA_W] &&
                    bus.rb_busy[s] === e.bb[s] &&
                    bus.rb_owner[s*TAG_W +: TAG_W] === e.bo[s*TAG_W +: TAG_W])
                    n_pass++;
                else
                    $display("FAIL rd_b slot%0d idx%0d t=%0t: got %h/%b/%h expected %h/%b/%h", s,
                             bus.rb_idx[s*IDX_W +: IDX_W], $time,
                             bus.rb_value[s*DATA_W +: DATA_W], bus.rb_busy[s], bus.rb_owner[s*TAG_W +: TAG_W],
                             e.bv[s*DATA_W +: DATA_W], e.bb[s], e.bo[s*TAG_W +: TAG_W]);
            end
        end
    end

    initial begin
        model_reset();
        clr();
        @(posedge clk);
        #1;
        do_reset();

        // Alloc then retire by the owner.
        clr(); set_alloc(0, 3, 5); set_rd(0, 3, 3); step();
        clr(); set_rd(0, 3, 3); step();
        clr(); set_wr(0, 3, 16'hBEEF, 5); set_rd(0, 3, 3); step();
        clr(); set_rd(0, 3, 3); step();

        // Stale retire leaves the newer owner in place.
        clr(); set_alloc(0, 4, 2); step();
        clr(); set_alloc(1, 4, 7); step();
        clr(); set_wr(0, 4, 16'h0011, 2); set_rd(0, 4, 4); step();
        clr(); set_rd(0, 4, 4); step();

        // Same-cycle retire and alloc on one register.
        clr(); set_alloc(2, 6, 1); step();
        clr(); set_wr(1, 6, 16'h1234, 1); set_alloc(0, 6, 9); step();
        clr(); set_rd(0, 6, 6); step();

        // Multiple ports on the same target.
        clr(); set_alloc(0, 5, 1); step();
        clr(); set_wr(0, 5, 1, 0); set_wr(2, 5, 2, 1);
        set_alloc(1, 8, 3); set_alloc(3, 8, 4); step();
        clr(); set_rd(0, 5, 8); set_rd(1, 8, 5); step();

        // r0 ignores alloc and retire.
        clr(); set_alloc(0, 0, 3); set_wr(0, 0, 16'hFFFF, 3); step();
        clr(); set_rd(0, 0, 0); step();

        // Reset after state has been written.
        clr(); set_rd(0, 3, 4); set_rd(1, 5, 6); set_rd(2, 8, 3); step();
        do_reset();

        for (int n = 0; n < 1500; n++) begin
            random_bundle();
            step();
            if (n == 700) do_reset();
        end

        clr();
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
